// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned DIGITS = 5;
  localparam int unsigned BIN_W  = 16;
  localparam int unsigned ITER   = 17;

  localparam int unsigned BIN_MAX_POS     = 32767;
  localparam int unsigned BIN_MAX_NEG_MAG = 32768;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    HOLD
  } state_t;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Input/output handshake bundle between an operand source and the converter.
interface bcd2bin_seq_if #(
  parameter int unsigned DIGITS = 5,
  parameter int unsigned BIN_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  sign_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  ovf;
  logic                  err;

  modport master (
    output in_valid, bcd_in, sign_in, out_ready,
    input  in_ready, out_valid, bin_out, ovf, err
  );

  modport slave (
    input  in_valid, bcd_in, sign_in, out_ready,
    output in_ready, out_valid, bin_out, ovf, err
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: subtract 3 from digits >= 8.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  // Digit correction after each right shift
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd8) o_digit = i_digit - 4'd3;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential signed BCD-to-binary converter, one reverse double-dabble step per clock.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = bcd_pkg::DIGITS,
  parameter int unsigned BIN_W  = bcd_pkg::BIN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_seq_if.slave  bus
);

  localparam int unsigned ITER    = $clog2(10**DIGITS);
  localparam int unsigned CNT_W   = $clog2(ITER + 1);
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned MAX_POS = (2**(BIN_W-1)) - 1;
  localparam int unsigned MAX_NEG = 2**(BIN_W-1);

  state_t                r_state, w_next;
  logic [BCD_W-1:0]      r_bcd;
  logic [ITER-1:0]       r_bin;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign;
  logic                  r_err_in;
  logic [BIN_W-1:0]      r_bin_out;
  logic                  r_ovf;
  logic                  r_err;

  logic [BCD_W+ITER-1:0] w_shift;
  logic [BCD_W-1:0]      w_bcd_sh;
  logic [BCD_W-1:0]      w_bcd_adj;
  logic                  w_bad_digit;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic [31:0]           w_mag;
  logic [BIN_W-1:0]      w_neg;

  assign w_shift  = {r_bcd, r_bin} >> 1;
  assign w_bcd_sh = w_shift[BCD_W+ITER-1 -: BCD_W];
  assign w_mag    = 32'(r_bin);
  assign w_neg    = '0 - r_bin[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (w_bcd_sh[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // Flag any non-decimal digit in the presented word
  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) w_bad_digit = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(ITER - 1)) w_next = FINISH;
      end
      FINISH: w_next = HOLD;
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load, shift/adjust, then saturate and sign the magnitude
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_err_in  <= 1'b0;
      r_bin_out <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_bcd    <= bus.bcd_in;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_sign   <= bus.sign_in;
            r_err_in <= w_bad_digit;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_adj;
          r_bin <= w_shift[ITER-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FINISH: begin
          r_err <= r_err_in;
          r_ovf <= 1'b0;
          if (r_err_in) begin
            r_bin_out <= '0;
          end else if (!r_sign && w_mag > MAX_POS) begin
            r_bin_out <= {1'b0, {(BIN_W-1){1'b1}}};
            r_ovf     <= 1'b1;
          end else if (r_sign && w_mag > MAX_NEG) begin
            r_bin_out <= {1'b1, {(BIN_W-1){1'b0}}};
            r_ovf     <= 1'b1;
          end else begin
            r_bin_out <= r_sign ? w_neg : r_bin[BIN_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.bin_out   = r_bin_out;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   lat;

  bcd2bin_seq_if #(.DIGITS(5), .BIN_W(16)) bif ();

  bcd2bin_seq #(.DIGITS(5), .BIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one word and return at the negedge after the acceptance edge
  task automatic accept(input logic [19:0] b, input logic s);
    int n;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.bcd_in   = b;
    bif.sign_in  = s;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  // Count clock edges after acceptance until out_valid is seen
  task automatic wait_out(output int l);
    l = 0;
    while (bif.out_valid !== 1'b1 && l < 40) begin
      @(posedge clk);
      @(negedge clk);
      l++;
    end
  endtask

  task automatic take();
    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk("post_xfer_out_valid", 32'(bif.out_valid), 32'd0);
    chk("post_xfer_in_ready", 32'(bif.in_ready), 32'd1);
  endtask

  task automatic convert(input string tag, input logic [19:0] b, input logic s,
                         input logic [15:0] eb, input logic eo, input logic ee);
    accept(b, s);
    wait_out(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd18);
    chk({tag, "_bin"}, 32'(bif.bin_out), 32'(eb));
    chk({tag, "_ovf"}, 32'(bif.ovf), 32'(eo));
    chk({tag, "_err"}, 32'(bif.err), 32'(ee));
    take();
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned m);
    logic [19:0] r;
    int unsigned x;
    x = m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  initial begin
    bif.in_valid  = 1'b0;
    bif.bcd_in    = '0;
    bif.sign_in   = 1'b0;
    bif.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_bin_out", 32'(bif.bin_out), 32'd0);
    chk("rst_ovf", 32'(bif.ovf), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert("pos_max", 20'h32767, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    convert("neg_max", 20'h32768, 1'b1, 16'h8000, 1'b0, 1'b0);
    convert("pos_ovf", 20'h32768, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    convert("neg_ovf", 20'h99999, 1'b1, 16'h8000, 1'b1, 1'b0);
    convert("pos_mid", 20'h01234, 1'b0, 16'h04D2, 1'b0, 1'b0);

    // Back-pressure: result held, new input ignored
    accept(20'h00123, 1'b1);
    wait_out(lat);
    chk("hold_latency", 32'(lat), 32'd18);
    chk("hold_bin_first", 32'(bif.bin_out), 32'h0000FF85);
    bif.in_valid = 1'b1;
    bif.bcd_in   = 20'h00001;
    bif.sign_in  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_bin", 32'(bif.bin_out), 32'h0000FF85);
      chk("hold_out_valid", 32'(bif.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bif.in_ready), 32'd0);
    end
    bif.in_valid = 1'b0;
    take();
    chk("retained_bin", 32'(bif.bin_out), 32'h0000FF85);

    convert("bad_digit", 20'h000A5, 1'b0, 16'h0000, 1'b0, 1'b1);
    convert("neg_zero", 20'h00000, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Reset mid-conversion lands on the 8th shift edge
    accept(20'h54321, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst_bin_out", 32'(bif.bin_out), 32'd0);
    convert("after_rst", 20'h00042, 1'b0, 16'h002A, 1'b0, 1'b0);

    // Round trip across the signed range with random back-pressure
    for (int i = 0; i < 42; i++) begin
      int v;
      int unsigned m;
      logic [31:0] ev;
      if (i == 40)      v = 32767;
      else if (i == 41) v = -1;
      else              v = -32768 + i * 1637;
      m  = (v < 0) ? int'(-v) : int'(v);
      ev = v;
      accept(to_bcd(m), v < 0);
      wait_out(lat);
      chk("rt_valid", 32'(bif.out_valid), 32'd1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("rt_bin", 32'(bif.bin_out), 32'(ev[15:0]));
      chk("rt_ovf", 32'(bif.ovf), 32'd0);
      chk("rt_err", 32'(bif.err), 32'd0);
      take();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
